// File: rtl/sound_req_sched_pkg.sv
// Shared types and defaults for the game sound request scheduler.
// Sound indices double as priority rank: lower index wins.
package sound_req_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_PLAY,
    ST_GAP
  } state_t;

  typedef enum logic [2:0] {
    SND_DEATH    = 3'd0,
    SND_EATGHOST = 3'd1,
    SND_EATFRUIT = 3'd2,
    SND_INTRO    = 3'd3,
    SND_EXTRAPAC = 3'd4,
    SND_WAKA     = 3'd5
  } sound_e;

  localparam int NUM_SOUNDS          = 6;
  localparam int NUM_QUEUED          = 5;  // waka is never queued
  localparam int ACK_TIMEOUT_DEFAULT = 16;
  localparam int GAP_CYCLES_DEFAULT  = 4535;

  function automatic logic [2:0] count_ones(input logic [NUM_SOUNDS-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_SOUNDS; i++) c = c + 3'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/sound_req_sched_prio_enc.sv
// Fixed-priority encoder: request vector -> one-hot grant, bit 0 highest.
module sound_prio_enc
  import sound_req_sched_pkg::*;
(
  input  logic [NUM_SOUNDS-1:0] req,
  output logic [NUM_SOUNDS-1:0] grant
);

  // Scan from lowest priority upward so the highest-priority request wins last.
  always_comb begin
    grant = '0;
    for (int i = NUM_SOUNDS - 1; i >= 0; i--) begin
      if (req[i]) grant = NUM_SOUNDS'(1) << i;
    end
  end

endmodule

// File: rtl/sound_req_sched.sv
// Sound request scheduler: queues game events, drives one player select at a time.
// Optional drop statistics counter enabled by defining SOUND_DROP_STATS_EN.
module sound_req_sched
  import sound_req_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_death,
  input  logic       ev_eatghost,
  input  logic       ev_eatfruit,
  input  logic       ev_intro,
  input  logic       ev_extrapac,
  input  logic       ev_waka,
  input  logic       sound_starts,
  input  logic       sound_ended,
  output logic       sel_death,
  output logic       sel_eatghost,
  output logic       sel_eatfruit,
  output logic       sel_intro,
  output logic       sel_extrapac,
  output logic       sel_waka,
  output logic       busy,
  output logic       ack_err,
  output logic [7:0] drop_cnt
);

  localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  typedef logic [TMR_W-1:0] tmr_t;
  localparam tmr_t ACK_LAST = tmr_t'(ACK_TIMEOUT - 1);
  localparam tmr_t GAP_LAST = tmr_t'(GAP_CYCLES - 1);

  state_t                state_q, state_d;
  logic [NUM_QUEUED-1:0] pend_q, pend_d;
  logic [NUM_SOUNDS-1:0] sel_q, sel_d;
  tmr_t                  tmr_q, tmr_d;
  logic                  ack_err_q, ack_err_d;

  logic [NUM_SOUNDS-1:0] ev_vec;
  logic [NUM_QUEUED-1:0] pend_merged;
  logic [NUM_SOUNDS-1:0] cand;
  logic [NUM_SOUNDS-1:0] grant;

  assign ev_vec = {ev_waka, ev_extrapac, ev_intro, ev_eatfruit, ev_eatghost, ev_death};

  // Death flushes every other queued sound, including ones arriving alongside it.
  assign pend_merged = ev_vec[SND_DEATH] ? (NUM_QUEUED'(1) << SND_DEATH)
                                         : (pend_q | ev_vec[NUM_QUEUED-1:0]);
  assign cand = {ev_waka && (pend_merged == '0), pend_merged};

  sound_prio_enc u_prio_enc (
    .req   (cand),
    .grant (grant)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_merged;
    sel_d     = sel_q;
    tmr_d     = tmr_q;
    ack_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          sel_d   = grant;
          pend_d  = pend_merged & ~grant[NUM_QUEUED-1:0];
          tmr_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sound_starts) begin
          state_d = ST_PLAY;
        end else if (tmr_q == ACK_LAST) begin
          sel_d     = '0;
          ack_err_d = 1'b1;
          tmr_d     = '0;
          state_d   = ST_GAP;
        end else begin
          tmr_d = tmr_q + tmr_t'(1);
        end
      end
      ST_PLAY: begin
        if (sound_ended) begin
          sel_d   = '0;
          tmr_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + tmr_t'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      sel_q     <= '0;
      tmr_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      tmr_q     <= tmr_d;
      ack_err_q <= ack_err_d;
    end
  end

`ifdef SOUND_DROP_STATS_EN
  logic       waka_drop;
  logic [2:0] drop_inc;
  logic [7:0] drop_q, drop_d;

  // Waka is lost whenever it is not the sound actually granted this cycle.
  assign waka_drop = ev_waka && !((state_q == ST_IDLE) && grant[SND_WAKA]);
  assign drop_inc  = count_ones({waka_drop, ev_vec[NUM_QUEUED-1:0] & pend_q});

  always_comb begin
    drop_d = drop_q;
    if ({1'b0, drop_q} + 9'(drop_inc) > 9'd255) drop_d = 8'd255;
    else                                        drop_d = drop_q + 8'(drop_inc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  assign sel_death    = sel_q[SND_DEATH];
  assign sel_eatghost = sel_q[SND_EATGHOST];
  assign sel_eatfruit = sel_q[SND_EATFRUIT];
  assign sel_intro    = sel_q[SND_INTRO];
  assign sel_extrapac = sel_q[SND_EXTRAPAC];
  assign sel_waka     = sel_q[SND_WAKA];
  assign busy         = (state_q != ST_IDLE);
  assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_sound_req_sched.sv
// Randomized scoreboard bench for sound_req_sched against a transaction-level model.
// Drop-count expectations follow SOUND_DROP_STATS_EN.
module tb_sound_req_sched;

  localparam int ACK = 16;
  localparam int GAP = 40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ev_death = 0, ev_eatghost = 0, ev_eatfruit = 0, ev_intro = 0, ev_extrapac = 0, ev_waka = 0;
  logic sound_starts = 0, sound_ended = 0;
  logic sel_death, sel_eatghost, sel_eatfruit, sel_intro, sel_extrapac, sel_waka;
  logic busy, ack_err;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  sound_req_sched #(.ACK_TIMEOUT(ACK), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .ev_death(ev_death), .ev_eatghost(ev_eatghost), .ev_eatfruit(ev_eatfruit),
    .ev_intro(ev_intro), .ev_extrapac(ev_extrapac), .ev_waka(ev_waka),
    .sound_starts(sound_starts), .sound_ended(sound_ended),
    .sel_death(sel_death), .sel_eatghost(sel_eatghost), .sel_eatfruit(sel_eatfruit),
    .sel_intro(sel_intro), .sel_extrapac(sel_extrapac), .sel_waka(sel_waka),
    .busy(busy), .ack_err(ack_err), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [5:0] sel;
    logic       busy;
    logic       ack;
    logic [7:0] drop;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: which sound owns the player, how long it waited, gap left.
  int m_cur = -1;
  bit m_playing = 0;
  int m_age = 0;
  int m_gap = 0;
  bit m_pend[5];
  int m_drops = 0;
  bit m_ack = 0;
  bit m_in_reset = 1;

  function automatic obs_t dut_obs();
    return '{sel: {sel_waka, sel_extrapac, sel_intro, sel_eatfruit, sel_eatghost, sel_death},
             busy: busy, ack: ack_err, drop: drop_cnt};
  endfunction

  function void model_reset();
    m_cur = -1; m_playing = 0; m_age = 0; m_gap = 0; m_drops = 0; m_ack = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endfunction

  function obs_t model_obs();
    obs_t o;
    o = '0;
    if (m_in_reset) return o;
    if (m_cur >= 0) o.sel[m_cur] = 1'b1;
    o.busy = (m_cur >= 0) || (m_gap > 0);
    o.ack  = m_ack;
`ifdef SOUND_DROP_STATS_EN
    o.drop = 8'(m_drops);
`endif
    return o;
  endfunction

  function void model_step(input logic [5:0] ev, input logic st, input logic en);
    int  lost;
    bit  was_idle;
    int  pick;
    lost = 0;
    m_ack = 0;
    was_idle = (m_cur < 0) && (m_gap == 0);
    for (int i = 0; i < 5; i++) begin
      if (ev[i] && m_pend[i]) lost++;
      if (ev[i]) m_pend[i] = 1;
    end
    if (ev[0]) for (int i = 1; i < 5; i++) m_pend[i] = 0;
    if (was_idle) begin
      pick = -1;
      for (int i = 4; i >= 0; i--) if (m_pend[i]) pick = i;
      if (pick >= 0) begin
        m_pend[pick] = 0;
        if (ev[5]) lost++;
      end else if (ev[5]) begin
        pick = 5;
      end
      if (pick >= 0) begin
        m_cur = pick; m_age = 0; m_playing = 0;
      end
    end else begin
      if (ev[5]) lost++;
      if (m_cur >= 0 && !m_playing) begin
        if (st) m_playing = 1;
        else begin
          m_age++;
          if (m_age == ACK) begin m_cur = -1; m_ack = 1; m_gap = GAP; end
        end
      end else if (m_cur >= 0) begin
        if (en) begin m_cur = -1; m_gap = GAP; end
      end else begin
        m_gap--;
      end
    end
    m_drops = (m_drops + lost > 255) ? 255 : m_drops + lost;
  endfunction

  function void check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
  endfunction

  // Monitor: one comparison per clock, away from the edge.
  obs_t prev_obs = '0;
  always @(posedge clk) begin
    obs_t got;
    obs_t want;
    cyc++;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = dut_obs();
      check("cycle_outputs", got, want);
      if (got.sel != 0 && prev_obs.sel == 0)
        $display("grant sel=%b cycle %0d drop_cnt=%0d", got.sel, cyc, got.drop);
      if (got.ack) $display("ack timeout cycle %0d", cyc);
      prev_obs = got;
    end
  end

  task automatic apply(input logic [5:0] ev, input logic st, input logic en);
    {ev_waka, ev_extrapac, ev_intro, ev_eatfruit, ev_eatghost, ev_death} = ev;
    sound_starts = st;
    sound_ended  = en;
    if (!m_in_reset) model_step(ev, st, en);
    exp_q.push_back(model_obs());
  endtask

  task automatic drive(input logic [5:0] ev, input logic st, input logic en);
    @(negedge clk);
    apply(ev, st, en);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(6'b0, 1'b0, 1'b0);
  endtask

  task automatic assert_reset(input string name);
    @(negedge clk);
    #2;
    reset = 1'b0;
    m_in_reset = 1;
    model_reset();
    exp_q.delete();
    exp_q.push_back('0);
    #1;
    check({name, "_sel"}, 16'(dut_obs().sel), 16'h0);
    check({name, "_busy_ack"}, 16'({busy, ack_err}), 16'h0);
    check({name, "_drop"}, 16'(drop_cnt), 16'h0);
    idle(3);
    @(negedge clk);
    reset = 1'b1;
    m_in_reset = 0;
    apply(6'b0, 1'b0, 1'b0);
  endtask

  localparam logic [5:0] E_DEATH = 6'b000001, E_GHOST = 6'b000010, E_FRUIT = 6'b000100,
                         E_INTRO = 6'b001000, E_XPAC  = 6'b010000, E_WAKA  = 6'b100000;

  initial begin
    logic [5:0] ev;
    // Reset state, observed while reset is held.
    @(negedge clk);
    #1;
    check("reset_sel", 16'(dut_obs().sel), 16'h0);
    check("reset_busy_ack", 16'({busy, ack_err}), 16'h0);
    check("reset_drop", 16'(drop_cnt), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    m_in_reset = 0;
    apply(6'b0, 1'b0, 1'b0);
    idle(2);

    // Eatfruit: event N, start N+2, end N+50, then full gap.
    drive(E_FRUIT, 0, 0);
    drive(6'b0, 0, 0);
    drive(6'b0, 1, 0);
    idle(47);
    drive(6'b0, 0, 1);
    idle(GAP + 4);

    // Waka and death together in IDLE.
    drive(E_DEATH | E_WAKA, 0, 0);
    drive(6'b0, 1, 0);
    idle(5);
    drive(6'b0, 0, 1);
    idle(GAP + 2);

    // Intro playing; ghost and fruit queued, then flushed by death.
    drive(E_INTRO, 0, 0);
    drive(6'b0, 1, 0);
    idle(3);
    drive(E_GHOST, 0, 0);
    drive(E_FRUIT, 0, 0);
    idle(2);
    drive(E_DEATH, 0, 0);
    idle(3);
    drive(6'b0, 0, 1);
    idle(GAP + 2);
    drive(6'b0, 1, 0);
    idle(2);
    drive(6'b0, 0, 1);
    idle(GAP + 4);

    // Acknowledge timeout.
    drive(E_XPAC, 0, 0);
    idle(ACK + 4);
    idle(GAP);

    // 300 waka pulses while a sound plays.
    drive(E_GHOST, 0, 0);
    drive(6'b0, 1, 0);
    for (int i = 0; i < 300; i++) drive(E_WAKA, 0, 0);
    idle(1);
    #1;
`ifdef SOUND_DROP_STATS_EN
    check("waka_saturate", 16'(drop_cnt), 16'd255);
`else
    check("waka_saturate", 16'(drop_cnt), 16'd0);
`endif
    drive(6'b0, 0, 1);
    idle(GAP + 2);

    // Reset mid-PLAY with eatghost pending: nothing replays after release.
    drive(E_INTRO, 0, 0);
    drive(6'b0, 1, 0);
    drive(E_GHOST, 0, 0);
    idle(2);
    assert_reset("midplay_reset");
    idle(GAP + 10);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      ev = '0;
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 99) < 2) ev[b] = 1'b1;
      if ($urandom_range(0, 99) < 6) ev[5] = 1'b1;
      drive(ev, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 5);
    end
    idle(4);
    @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sound_req_sched.md
SOUND_REQ_SCHED -- requirements
Module: sound_req_sched

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, max clk cycles from select assert to sound_starts.
REQ-002 Parameter GAP_CYCLES, default 4535, silent clk cycles between sounds (one 22.05 kHz sample at 100 MHz).
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ev_death, ev_eatghost, ev_eatfruit, ev_intro, ev_extrapac, ev_waka  in  1 each  single-cycle game event pulses.
REQ-006 sound_starts  in  1  player start acknowledge pulse.
REQ-007 sound_ended  in  1  player end-of-sound pulse.
REQ-008 sel_death, sel_eatghost, sel_eatfruit, sel_intro, sel_extrapac, sel_waka  out  1 each  player select lines, at most one high.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 ack_err  out  1  one-cycle pulse on acknowledge timeout.
REQ-011 drop_cnt  out  8  saturating count of coalesced or dropped events.

Function
REQ-012 Pending flag per sound except waka; an event pulse sets its flag, a grant clears it.
REQ-013 Priority high to low: death, eatghost, eatfruit, intro, extrapac, waka.
REQ-014 FSM states: IDLE, REQ, PLAY, GAP.
REQ-015 IDLE: if any pending or event this cycle, grant highest, assert its sel next cycle, go REQ (latency: event at cycle N -> sel high at N+1).
REQ-016 REQ: hold sel; sound_starts -> PLAY; ACK_TIMEOUT cycles without it -> drop sel, pulse ack_err, go GAP.
REQ-017 PLAY: hold sel until sound_ended; sel low the cycle after sound_ended, go GAP.
REQ-018 GAP: all sel low, count GAP_CYCLES, then IDLE.
REQ-019 Event for a sound already pending: flag stays 1, drop_cnt +1.
REQ-020 Event for the sound currently in REQ/PLAY: sets its pending flag (replays after GAP).
REQ-021 ev_waka while busy or any flag pending: discarded, drop_cnt +1; waka never queued.
REQ-022 ev_death clears all other pending flags same cycle (not counted as drops); never preempts a sound in PLAY.
REQ-023 Several events in one cycle: all flags set, highest granted.
REQ-024 sound_ended in REQ or IDLE is ignored; sound_starts outside REQ is ignored.
REQ-025 drop_cnt saturates at 255, no wrap.

Reset
REQ-026 On reset low, immediately: FSM IDLE, all flags 0, all sel 0, busy 0, ack_err 0, drop_cnt 0, counters 0.
REQ-027 Reset mid-PLAY abandons the sound; no replay after release.

Configuration
REQ-028 Macro SOUND_DROP_STATS_EN defined: drop_cnt per REQ-019/021/025.
REQ-029 Macro undefined: drop_cnt tied to 0, counter logic absent, port kept.

Structure
REQ-030 Shared package holds FSM state typedef, sound index enum (priority order), ACK_TIMEOUT and GAP_CYCLES defaults.
REQ-031 One sub-module: sound_prio_enc, combinational fixed-priority encoder pending -> one-hot grant.

Verification
REQ-032 ev_eatfruit at N, sound_starts at N+2, sound_ended at N+50 -> sel_eatfruit high N+1..N+50, low N+51, busy low at N+51+GAP_CYCLES.
REQ-033 ev_waka and ev_death same cycle in IDLE -> sel_death granted, waka dropped, drop_cnt=1.
REQ-034 ev_intro, then ev_eatghost and ev_eatfruit during PLAY, then ev_death -> after intro ends, only sel_death granted; eatghost/eatfruit flushed.
REQ-035 Select asserted, no sound_starts for 16 cycles -> ack_err one pulse, sel low, GAP entered.
REQ-036 300 ev_waka pulses while busy -> drop_cnt=255 (with macro), 0 (without).
REQ-037 reset low during PLAY with eatghost pending -> all outputs 0 immediately, no sel after release.
